// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline-stage register: LANES x WIDTH payload, valid/ready,
// synchronous flush to bubble, and an optional two-entry skid buffer.
module pipe_stage_reg #(
  parameter int unsigned LANES      = 4,
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned SKID       = 1,
  parameter              BUBBLE_VAL = 32'h0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_data,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic [1:0]             occupancy
);

  localparam logic [WIDTH-1:0]       BUBBLE_LANE = WIDTH'(BUBBLE_VAL);
  localparam logic [LANES*WIDTH-1:0] BUBBLE_ALL  = {LANES{BUBBLE_LANE}};

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [LANES*WIDTH-1:0] main_q, main_d;
  logic [LANES*WIDTH-1:0] skid_q, skid_d;
  logic                   in_ready_q, in_ready_d;
  logic                   accept, emit;

  // Skid mode exports a flop so stalls never ripple combinationally upstream.
  assign in_ready  = (SKID != 0) ? in_ready_q : (out_ready || !out_valid);
  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;
  assign occupancy = state_q;
  assign accept    = in_valid && in_ready;
  assign emit      = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      main_d  = BUBBLE_ALL;
      skid_d  = BUBBLE_ALL;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d = ONE;
            main_d  = in_data;
          end
        end
        ONE: begin
          if (accept && emit) begin
            main_d = in_data;
          end else if (accept) begin
            // Only reachable in skid mode: single-entry in_ready is low here.
            state_d = TWO;
            skid_d  = in_data;
          end else if (emit) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (emit) begin
            state_d = ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
    in_ready_d = (state_d != TWO);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      main_q     <= BUBBLE_ALL;
      skid_q     <= BUBBLE_ALL;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

endmodule
